// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes ps2_clk/ps2_data, assembles
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and emits one pulse per frame.
module ps2_frame_rx #(
    parameter int TIMEOUT = 10000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       write,
    output logic       parity_err,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic ps2_clk_s1, ps2_clk_s2, ps2_clk_prev;
    logic ps2_data_s1, ps2_data_s2;

    state_t      state, state_next;
    logic [2:0]  count, count_next;
    logic [7:0]  shift, shift_next;
    logic        parity, parity_next;
    logic [15:0] timer, timer_next;
    logic [7:0]  data_next;
    logic        write_next, parity_err_next, frame_err_next;

    logic fall;
    logic sample;
    logic timeout_hit;

    // Synchronizers reset to the idle-high line level so release never fakes an edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2_clk_s1   <= 1'b1;
            ps2_clk_s2   <= 1'b1;
            ps2_clk_prev <= 1'b1;
            ps2_data_s1  <= 1'b1;
            ps2_data_s2  <= 1'b1;
        end else begin
            ps2_clk_s1   <= ps2_clk;
            ps2_clk_s2   <= ps2_clk_s1;
            ps2_clk_prev <= ps2_clk_s2;
            ps2_data_s1  <= ps2_data;
            ps2_data_s2  <= ps2_data_s1;
        end
    end

    assign fall        = ps2_clk_prev & ~ps2_clk_s2;
    assign sample      = ps2_data_s2;
    assign timeout_hit = (timer == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            count      <= 3'd0;
            shift      <= 8'h00;
            parity     <= 1'b0;
            timer      <= 16'd0;
            data_out   <= 8'h00;
            write      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            shift      <= shift_next;
            parity     <= parity_next;
            timer      <= timer_next;
            data_out   <= data_next;
            write      <= write_next;
            parity_err <= parity_err_next;
            frame_err  <= frame_err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next      = state;
        count_next      = count;
        shift_next      = shift;
        parity_next     = parity;
        timer_next      = timer + 16'd1;
        data_next       = data_out;
        write_next      = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;

        // A falling edge always wins over the timeout terminal count.
        if (state == IDLE) begin
            timer_next = 16'd0;
            count_next = 3'd0;
            if (fall && !sample) begin
                state_next = DATA;
            end
        end else if (fall) begin
            timer_next = 16'd0;
            case (state)
                DATA: begin
                    shift_next = {sample, shift[7:1]};
                    if (count == 3'd7) begin
                        state_next = PARITY;
                        count_next = 3'd0;
                    end else begin
                        count_next = count + 3'd1;
                    end
                end
                PARITY: begin
                    parity_next = sample;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    count_next = 3'd0;
                    if (!sample) begin
                        frame_err_next = 1'b1;
                    end else if (^{shift, parity}) begin
                        write_next = 1'b1;
                        data_next  = shift;
                    end else begin
                        parity_err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_next     = IDLE;
            count_next     = 3'd0;
            timer_next     = 16'd0;
            frame_err_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: a stimulus process drives PS/2 frames and queues
// the expected outcome of each; a monitor pops and compares whenever a pulse appears.
module tb_ps2_frame_rx;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    typedef enum int { EV_WRITE, EV_PERR, EV_FERR } ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data_out;
    logic       write, parity_err, frame_err;

    int  compared = 0;
    int  mismatched = 0;
    ev_t exp_q[$];
    logic [7:0] model_data = 8'h00;

    ps2_frame_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_out   (data_out),
        .write      (write),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference outcome of a complete frame, from the framing rules alone.
    function automatic ev_t frame_outcome(input logic [7:0] b, input logic par, input logic stop);
        ev_t e;
        if (!stop) begin
            e.kind = EV_FERR;
        end else if ((($countones(b) + int'(par)) % 2) == 1) begin
            e.kind = EV_WRITE;
        end else begin
            e.kind = EV_PERR;
        end
        e.data = (e.kind == EV_WRITE) ? b : model_data;
        return e;
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of the frame; a full frame queues its expected outcome.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int nbits);
        logic [10:0] bits;
        ev_t e;
        bits = {stop, par, b, 1'b0};
        if (nbits == 11) begin
            e = frame_outcome(b, par, stop);
            model_data = e.data;
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, ~(^b), 1'b1, 11);
    endtask

    task automatic timeout_frame(input logic [7:0] b, input int nbits);
        ev_t e;
        e.kind = EV_FERR;
        e.data = model_data;
        exp_q.push_back(e);
        send_frame(b, 1'b0, 1'b1, nbits);
        repeat (TIMEOUT + 2) @(negedge clk);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check({tag, "_data_out"}, data_out, 8'h00);
        check({tag, "_pulses"}, {write, parity_err, frame_err}, 3'b000);
        model_data = 8'h00;
        repeat (3) @(negedge clk);
        check({tag, "_hold_pulses"}, {write, parity_err, frame_err}, 3'b000);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clrn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every pulse and guards the hold/exclusivity rules.
    logic       prev_any = 1'b0;
    logic [7:0] last_data = 8'h00;
    always @(negedge clk) begin
        logic any;
        ev_t e;
        if (!clrn) begin
            prev_any  = 1'b0;
            last_data = 8'h00;
        end else begin
            any = write | parity_err | frame_err;
            if (any) begin
                check("onehot_pulse", $countones({write, parity_err, frame_err}), 1);
                check("no_back_to_back", prev_any, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {write, parity_err, frame_err}, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind",
                          write ? EV_WRITE : (parity_err ? EV_PERR : EV_FERR), e.kind);
                    check("data_out", data_out, e.data);
                end
                last_data = data_out;
            end else begin
                check("data_hold", data_out, last_data);
            end
            prev_any = any;
        end
    end

    initial begin
        int waited;
        clrn = 1'b0;
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_pulses", {write, parity_err, frame_err}, 3'b000);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);

        good_frame(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        send_frame(8'hF0, 1'b1, 1'b0, 11);
        timeout_frame(8'hAA, 6);
        send_frame(8'hF0, 1'b1, 1'b1, 11);
        send_bit(1'b1);
        repeat (3 * HALF) @(negedge clk);
        good_frame(8'h1C);
        send_frame(8'h5A, 1'b1, 1'b1, 5);
        reset_pulse("midframe_reset");
        send_frame(8'h5A, 1'b1, 1'b1, 11);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            int sel;
            b   = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                send_bit(1'b1);
                repeat (3 * HALF) @(negedge clk);
                good_frame(b);
            end else if (sel == 1) begin
                timeout_frame(b, $urandom_range(1, 10));
            end else begin
                send_frame(b, 1'($urandom), ($urandom_range(0, 3) != 0), 11);
            end
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 10000, meaning the clk cycles allowed between ps2_clk falling edges inside a frame; legal range is 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clrn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ps2_clk, input, 1 bit: PS/2 device clock, asynchronous to clk, idle high.
REQ-005 The block SHALL have port ps2_data, input, 1 bit: PS/2 device data, asynchronous to clk, idle high.
REQ-006 The block SHALL have port data_out, output, 8 bits: last correctly received byte; it connects directly to the downstream FIFO data_in.
REQ-007 The block SHALL have port write, output, 1 bit: a one-clk pulse marking data_out valid; it connects directly to the downstream FIFO write.
REQ-008 The block SHALL have port parity_err, output, 1 bit: a one-clk pulse on a frame with bad odd parity.
REQ-009 The block SHALL have port frame_err, output, 1 bit: a one-clk pulse on a bad stop bit or an inter-edge timeout.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer, and a third register on ps2_clk SHALL hold the previous synchronized value.
REQ-011 A falling-edge event E SHALL be a cycle in which the previous synchronized ps2_clk is 1 and the current one is 0.
REQ-012 At E, the synchronized ps2_data value SHALL be the sampled bit; no other cycle samples data.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-014 In IDLE, an E with sampled bit 0 (start bit) SHALL move the FSM to DATA with bit count 0; an E with sampled bit 1 SHALL be ignored, and the FSM stays in IDLE.
REQ-015 In DATA, each E SHALL shift the sampled bit into the shift register LSB-first; after the 8th bit (count 7), the FSM SHALL move to PARITY.
REQ-016 In PARITY, an E SHALL store the parity bit and move the FSM to STOP.
REQ-017 In STOP, an E SHALL return the FSM to IDLE and produce exactly one outcome, as defined in REQ-018 to REQ-020.
REQ-018 Stop bit 1 and odd parity (XOR of 8 data bits and the parity bit equals 1) SHALL load data_out with the byte and assert write in the cycle after the stop-bit E.
REQ-019 Stop bit 1 with even parity SHALL assert parity_err for one cycle (same timing as write); write stays 0 and data_out is unchanged.
REQ-020 Stop bit 0 SHALL assert frame_err for one cycle, regardless of parity; write stays 0 and data_out is unchanged.
REQ-021 A 16-bit timeout counter SHALL clear to 0 on every E and in IDLE, and increment each cycle in DATA, PARITY or STOP.
REQ-022 When the timeout counter reaches TIMEOUT, the FSM SHALL go to IDLE, clear the bit count, pulse frame_err once and leave data_out unchanged.
REQ-023 write, parity_err and frame_err SHALL be registered, mutually exclusive and never high in two consecutive cycles.
REQ-024 data_out SHALL change only in a write cycle.
REQ-025 The block SHALL NOT observe FIFO status; a FIFO overflow is the downstream block's concern, and write is issued regardless.
REQ-026 If an E and the timeout terminal count occur in the same cycle, the E SHALL take priority, and the counter clears.

Reset
REQ-027 While clrn = 0, regardless of clk, the block SHALL force: FSM = IDLE, bit count = 0, timeout counter = 0, shift register = 0, data_out = 8'h00, write = 0, parity_err = 0, frame_err = 0, and all synchronizer and edge registers = 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no pulse on any output.
REQ-029 After reset release, the first falling edge SHALL be detected no earlier than 2 cycles after ps2_clk goes low.

Verification
REQ-030 The bench SHALL cover a good frame: start 0, byte 8'h1C LSB-first, parity 0, stop 1 -> one write pulse with data_out = 8'h1C, and no error pulse.
REQ-031 The bench SHALL cover a bad-parity frame: byte 8'h1C with parity 1 -> one parity_err pulse, no write, data_out stays 8'h1C.
REQ-032 The bench SHALL cover a bad stop bit: byte 8'hF0, parity 1, stop 0 -> one frame_err pulse, no write, data_out unchanged.
REQ-033 The bench SHALL cover timeout recovery: start plus 5 data bits, then ps2_clk held high for TIMEOUT+2 cycles -> one frame_err pulse and FSM in IDLE; then a full frame of 8'hF0 with parity 1 -> write with data_out = 8'hF0.
REQ-034 The bench SHALL cover a false start: a falling edge with ps2_data = 1 in IDLE -> no state change and no pulses; the following good frame of 8'h1C is received normally.
REQ-035 The bench SHALL cover reset mid-frame: clrn pulsed low after 4 data bits -> all outputs at reset values, no pulses; the next full frame of 8'h5A with parity 1 -> write with data_out = 8'h5A.
